// File: rtl/mips_exec_alu_if.sv
// Operand/instruction bundle into the execute-stage ALU and its registered result.
// master drives the instruction and operands; slave is the ALU.
interface mips_exec_alu_if #(
   parameter int WIDTH = 32
);
   logic [31:0]      Instruction;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [4:0]       shamt;
   logic [WIDTH-1:0] O;
   logic             zero;

   modport master (
      output Instruction, A, B, shamt,
      input  O, zero
   );

   modport slave (
      input  Instruction, A, B, shamt,
      output O, zero
   );
endinterface

// File: rtl/mips_exec_alu.sv
// Registered MIPS execute-stage ALU: decodes the raw instruction word, computes the result
// and a zero flag for beq/bne resolution, one cycle of latency.
module mips_exec_alu #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   mips_exec_alu_if.slave     bus
);

   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic [15:0]      imm16;
   logic [WIDTH-1:0] imm_se;
   logic [WIDTH-1:0] imm_ze;
   logic [WIDTH-1:0] o_d;
   logic [WIDTH-1:0] o_q;
   logic             zero_d;
   logic             zero_q;
   logic             unused_fields;

   assign opcode = bus.Instruction[31:26];
   assign funct  = bus.Instruction[5:0];
   assign imm16  = bus.Instruction[15:0];
   assign imm_se = {{(WIDTH-16){imm16[15]}}, imm16};
   assign imm_ze = {{(WIDTH-16){1'b0}}, imm16};

   // Register specifiers are resolved upstream; only the shamt port drives shifts.
   assign unused_fields = ^bus.Instruction[25:16];

   always_comb begin
      o_d = '0;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h21:        o_d = bus.A + bus.B;
               6'h23:        o_d = bus.A - bus.B;
               6'h27, 6'h2F: o_d = ~(bus.A | bus.B);
               6'h00:        o_d = bus.B << bus.shamt;
               6'h02:        o_d = bus.B >> bus.shamt;
               default:      o_d = '0;
            endcase
         end
         6'h09:        o_d = bus.A + imm_se;
         6'h0C:        o_d = bus.A & imm_ze;
         6'h04, 6'h05: o_d = bus.A - bus.B;
         6'h23, 6'h2B: o_d = bus.A + imm_se;
         default:      o_d = '0;
      endcase
      zero_d = (o_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_q    <= '0;
         zero_q <= 1'b0;
      end else begin
         o_q    <= o_d;
         zero_q <= zero_d;
      end
   end

   assign bus.O    = o_q;
   assign bus.zero = zero_q;

endmodule

// File: tb/tb_mips_exec_alu.sv
// Scoreboard bench for mips_exec_alu: expected results are queued when operands are driven
// and popped when the registered result appears one edge later.
module tb_mips_exec_alu;

   typedef struct packed {
      logic [31:0] o;
      logic        z;
   } exp_t;

   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   total_cnt;
   exp_t sb_q[$];

   mips_exec_alu_if #(.WIDTH(32)) bus ();

   mips_exec_alu #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
      $fatal(1, "timeout");
   end

   // Independent reference of the instruction subset, written from the instruction table.
   function automatic logic [31:0] ref_alu(input logic [31:0] ins, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
      logic [31:0] se;
      logic [31:0] res;
      se  = {{16{ins[15]}}, ins[15:0]};
      res = 32'h0;
      if (ins[31:26] == 6'h00) begin
         if (ins[5:0] == 6'h21)      res = a + b;
         else if (ins[5:0] == 6'h23) res = a - b;
         else if (ins[5:0] == 6'h27 || ins[5:0] == 6'h2F) res = ~a & ~b;
         else if (ins[5:0] == 6'h00) res = b << sh;
         else if (ins[5:0] == 6'h02) res = b >> sh;
      end else if (ins[31:26] == 6'h09 || ins[31:26] == 6'h23 || ins[31:26] == 6'h2B) begin
         res = a + se;
      end else if (ins[31:26] == 6'h0C) begin
         res = a & {16'h0, ins[15:0]};
      end else if (ins[31:26] == 6'h04 || ins[31:26] == 6'h05) begin
         res = a + ~b + 32'h1;
      end
      return res;
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] eo, input logic ez);
      exp_t e;
      @(negedge clk);
      bus.Instruction = ins;
      bus.A           = a;
      bus.B           = b;
      bus.shamt       = sh;
      e.o = eo;
      e.z = ez;
      sb_q.push_back(e);
   endtask

   task automatic test_reset();
      exp_t e;
      rst_n           = 1'b0;
      bus.Instruction = 32'h03E0F823;
      bus.A           = 32'h0FB7AFF0;
      bus.B           = 32'hA00D0FF0;
      bus.shamt       = 5'd2;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++;
      if (bus.O !== 32'h0 || bus.zero !== 1'b0)
         $display("FAIL reset_hold: O=%h zero=%b required O=00000000 zero=0", bus.O, bus.zero);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      e.o = 32'h6FAAA000;
      e.z = 1'b0;
      sb_q.push_back(e);
      #1;
      total_cnt++;
      if (bus.O !== 32'h0 || bus.zero !== 1'b0)
         $display("FAIL reset_release_pre_edge: O=%h zero=%b required O=00000000 zero=0", bus.O, bus.zero);
      else pass_cnt++;
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      total_cnt++;
      if (bus.O !== e.o || bus.zero !== e.z)
         $display("FAIL reset_first_subu: O=%h zero=%b required O=%h zero=%b", bus.O, bus.zero, e.o, e.z);
      else pass_cnt++;
   endtask

   task automatic test_rtype();
      logic [31:0] ins[5] = '{32'h03E0F821, 32'h03E0F82F, 32'h03E0F827, 32'h03E0F800, 32'h03E0F802};
      logic [31:0] exp[5] = '{32'hAFC4BFE0, 32'h5040500F, 32'h5040500F, 32'h80343FC0, 32'h280343FC};
      string       nm[5]  = '{"addu", "nor_2f", "nor_27", "sll", "srl"};
      exp_t        e;
      for (int i = 0; i < 5; i++) begin
         drive(ins[i], 32'h0FB7AFF0, 32'hA00D0FF0, 5'd2, exp[i], 1'b0);
         @(posedge clk);
         #1;
         total_cnt++;
         if (sb_q.size() == 0) begin
            $display("FAIL rtype_%s: scoreboard empty", nm[i]);
         end else begin
            e = sb_q.pop_front();
            if (bus.O !== e.o || bus.zero !== e.z)
               $display("FAIL rtype_%s: O=%h zero=%b required O=%h zero=%b", nm[i], bus.O, bus.zero, e.o, e.z);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_itype();
      logic [31:0] ins[4] = '{32'h27E0F823, 32'h8FE0F823, 32'hAFE0F823, 32'h33E0F823};
      logic [31:0] exp[4] = '{32'h0FB7A813, 32'h0FB7A813, 32'h0FB7A813, 32'h0000A820};
      string       nm[4]  = '{"addiu", "lw", "sw", "andi"};
      exp_t        e;
      for (int i = 0; i < 4; i++) begin
         drive(ins[i], 32'h0FB7AFF0, 32'hA00D0FF0, 5'd2, exp[i], 1'b0);
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         total_cnt++;
         if (bus.O !== e.o || bus.zero !== e.z)
            $display("FAIL itype_%s: O=%h zero=%b required O=%h zero=%b", nm[i], bus.O, bus.zero, e.o, e.z);
         else pass_cnt++;
      end
   endtask

   task automatic test_branch_boundary_unsupported();
      logic [31:0] ins[9] = '{32'h13E0F823, 32'h17E0F823, 32'h03E0F821, 32'h03E0F823, 32'h03E0F800,
                              32'h03E0F802, 32'h03E0F800, 32'hFC00F823, 32'h03E0F808};
      logic [31:0] a[9]   = '{32'h12345678, 32'h0FB7AFF0, 32'hFFFFFFFF, 32'h0, 32'h0FB7AFF0,
                              32'h0FB7AFF0, 32'h0FB7AFF0, 32'h0FB7AFF0, 32'h0FB7AFF0};
      logic [31:0] b[9]   = '{32'h12345678, 32'hA00D0FF0, 32'h1, 32'h1, 32'hA00D0FF0,
                              32'h80000000, 32'h00000001, 32'hA00D0FF0, 32'hA00D0FF0};
      logic [4:0]  sh[9]  = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd0, 5'd31, 5'd31, 5'd2, 5'd2};
      logic [31:0] eo[9]  = '{32'h0, 32'h6FAAA000, 32'h0, 32'hFFFFFFFF, 32'hA00D0FF0,
                              32'h1, 32'h80000000, 32'h0, 32'h0};
      logic        ez[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      string       nm[9]  = '{"beq_equal", "bne", "addu_wrap", "subu_underflow", "sll_shamt0",
                              "srl_shamt31", "sll_shamt31", "unsupported_op3f", "unsupported_funct08"};
      exp_t        e;
      for (int i = 0; i < 9; i++) begin
         drive(ins[i], a[i], b[i], sh[i], eo[i], ez[i]);
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         total_cnt++;
         if (bus.O !== e.o || bus.zero !== e.z)
            $display("FAIL %s: O=%h zero=%b required O=%h zero=%b", nm[i], bus.O, bus.zero, e.o, e.z);
         else pass_cnt++;
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      drive(32'h03E0F821, 32'h0FB7AFF0, 32'hA00D0FF0, 5'd2, 32'hAFC4BFE0, 1'b0);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      total_cnt++;
      if (bus.O !== e.o || bus.zero !== e.z)
         $display("FAIL async_pre_load: O=%h zero=%b required O=%h zero=%b", bus.O, bus.zero, e.o, e.z);
      else pass_cnt++;
      // New in-flight op, then reset lands mid-cycle before it is captured.
      drive(32'h03E0F823, 32'h0FB7AFF0, 32'hA00D0FF0, 5'd2, 32'h6FAAA000, 1'b0);
      void'(sb_q.pop_front());
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (bus.O !== 32'h0 || bus.zero !== 1'b0)
         $display("FAIL async_immediate: O=%h zero=%b required O=00000000 zero=0", bus.O, bus.zero);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if (bus.O !== 32'h0 || bus.zero !== 1'b0)
         $display("FAIL async_inflight_discard: O=%h zero=%b required O=00000000 zero=0", bus.O, bus.zero);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      e.o = 32'h6FAAA000;
      e.z = 1'b0;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      total_cnt++;
      if (bus.O !== e.o || bus.zero !== e.z)
         $display("FAIL async_recover: O=%h zero=%b required O=%h zero=%b", bus.O, bus.zero, e.o, e.z);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [5:0]  ops[8]    = '{6'h00, 6'h09, 6'h0C, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h3F};
      logic [5:0]  functs[8] = '{6'h21, 6'h23, 6'h27, 6'h2F, 6'h00, 6'h02, 6'h08, 6'h2A};
      logic [31:0] ins;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] r;
      exp_t        e;
      for (int i = 0; i < 24; i++) begin
         ins = $urandom();
         ins[31:26] = ops[$urandom_range(0, 7)];
         if (ins[31:26] == 6'h00) ins[5:0] = functs[$urandom_range(0, 7)];
         a  = (i % 4 == 0) ? 32'h0 : $urandom();
         b  = (i % 5 == 0) ? a : $urandom();
         sh = 5'($urandom_range(0, 31));
         r  = ref_alu(ins, a, b, sh);
         drive(ins, a, b, sh, r, (r == 32'h0));
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         total_cnt++;
         if (bus.O !== e.o || bus.zero !== e.z)
            $display("FAIL b2b_%0d ins=%h: O=%h zero=%b required O=%h zero=%b",
                     i, ins, bus.O, bus.zero, e.o, e.z);
         else pass_cnt++;
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_rtype();
      test_itype();
      test_branch_boundary_unsupported();
      test_async_reset();
      test_back_to_back();
      total_cnt++;
      if (sb_q.size() != 0)
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mips_exec_alu.md
Name: mips_exec_alu

Overview:
- Registered 32-bit MIPS execute-stage ALU.
- Decodes the full 32-bit instruction word directly (opcode [31:26], funct [5:0], imm16 [15:0]) and computes the result for a subset of R-type and I-type instructions.
- Produces a zero flag that the surrounding datapath uses for beq/bne branch resolution.
- Sits between the register-file read stage and the memory/writeback stage.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Instruction  input  32  current instruction word
- A  input  32  operand A (rs value)
- B  input  32  operand B (rt value)
- shamt  input  5  shift amount for sll/srl; Instruction[10:6] is ignored
- O  output  32  registered result
- zero  output  1  registered flag, 1 when the next-state O equals 0

Behaviour:
- Reset: rst_n low forces O=0 and zero=0 immediately (asynchronous). Both hold until the first rising clk edge after rst_n goes high.
- Latency: 1 cycle. Inputs sampled at a rising edge appear on O/zero after that edge. There is no enable; a new operation is accepted every cycle.
- Result mux and zero detect are combinational. O and zero are both captured in flops.
- Arithmetic is 32-bit modulo (wrap-around): no overflow trap and no carry output.
- R-type (opcode 6'h00), selected by funct:
  - 6'h21 addu: O = A + B
  - 6'h23 subu: O = A - B
  - 6'h27 and 6'h2F nor: O = ~(A | B). Both encodings are accepted.
  - 6'h00 sll: O = B << shamt (logical, zero fill)
  - 6'h02 srl: O = B >> shamt (logical, zero fill)
  - Any other funct: O = 0
- I-type, selected by opcode. SE = sign-extended imm16, ZE = zero-extended imm16. B is unused except for beq/bne.
  - 6'h09 addiu: O = A + SE
  - 6'h0C andi: O = A & ZE
  - 6'h04 beq and 6'h05 bne: O = A - B
  - 6'h23 lw and 6'h2B sw: O = A + SE (effective address)
  - Any other opcode: O = 0
- zero = (next O == 0) for every instruction, including unsupported ones, where zero=1. Branch taken/not-taken is decided outside this block: beq takes on zero=1, bne on zero=0.
- Shift edge cases: shamt=0 gives O = B; shamt=31 keeps only 1 bit.
- Reset asserted mid-operation discards the in-flight result.
- Output changes only on clk edges or on reset.

Test Plan:
- Reset: hold rst_n=0, then release; apply subu (Instruction 32'h03E0F823) with A=32'h0FB7AFF0, B=32'hA00D0FF0 -> O=0, zero=0 during reset; after 1 edge O=32'h6FAAA000, zero=0.
- R-type sweep, same A/B, shamt=2:
  - addu 32'h03E0F821 -> O=32'hAFC4BFE0
  - nor 32'h03E0F82F -> O=32'h5040500F
  - sll 32'h03E0F800 -> O=32'h80343FC0
  - srl 32'h03E0F802 -> O=32'h280343FC
- I-type sweep, same A:
  - addiu 32'h27E0F823 -> O=32'h0FB7A813
  - lw 32'h8FE0F823 -> O=32'h0FB7A813
  - sw 32'hAFE0F823 -> O=32'h0FB7A813
  - andi 32'h33E0F823 -> O=32'h0000A820
- Branch: beq 32'h13E0F823 with A=B=32'h12345678 -> O=0, zero=1. bne 32'h17E0F823 with the original A/B -> O=32'h6FAAA000, zero=0.
- Boundaries:
  - addu A=32'hFFFFFFFF, B=1 -> O=0, zero=1 (wrap)
  - subu A=0, B=1 -> O=32'hFFFFFFFF
  - sll shamt=0 -> O=B
  - srl shamt=31, B=32'h80000000 -> O=1
- Unsupported: opcode 6'h3F, or R-type funct 6'h08 -> O=0, zero=1.
- Async reset: assert rst_n low between clock edges while O is nonzero -> O=0 and zero=0 immediately, before the next edge.
